dcache_wb_controller: RTL

//  Direct-mapped, write-back, write-allocate data cache between the CPU load/store unit and the
//  128-bit block data memory. Word hits are served from local arrays with zero added latency.

---
 rtl/dcache_wb_controller_if.sv | 26 ++
 rtl/dcache_wb_controller.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/dcache_wb_controller_if.sv
// CPU-side and memory-side signal bundle for the write-back data cache controller.
// The cache takes the slave view; the CPU/memory environment takes the master view.
interface dcache_wb_controller_if;
    logic         read;
    logic         write;
    logic [31:0]  address;
    logic [31:0]  writedata;
    logic [31:0]  readdata;
    logic         busywait;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/dcache_wb_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits complete with no added latency; misses evict a dirty victim, then fetch the new block.
module dcache_wb_controller #(
    parameter int unsigned NUM_SETS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    dcache_wb_controller_if.slave bus
);
    localparam int unsigned INDEX_W = $clog2(NUM_SETS);
    localparam int unsigned TAG_W   = 28 - INDEX_W;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2,
        UPDATE    = 2'd3
    } state_t;

    state_t state, next_state;

    logic [BLOCK_W-1:0] data_array [NUM_SETS];
    logic [TAG_W-1:0]   tag_array  [NUM_SETS];
    logic [NUM_SETS-1:0] valid;
    logic [NUM_SETS-1:0] dirty;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   cpu_tag;
    logic [1:0]         word_sel;
    logic [WORD_W-1:0]  hit_word;
    logic               hit;
    logic               access;
    logic               idle;
    logic               read_hit;
    logic               write_hit;
    logic               unused_addr;

    logic               mem_read_q,      mem_read_d;
    logic               mem_write_q,     mem_write_d;
    logic [BADDR_W-1:0] mem_address_q,   mem_address_d;
    logic [BLOCK_W-1:0] mem_writedata_q, mem_writedata_d;
    logic [WORD_W-1:0]  readdata_q,      readdata_d;

    assign index       = bus.address[4 +: INDEX_W];
    assign cpu_tag     = bus.address[31 -: TAG_W];
    assign word_sel    = bus.address[3:2];
    assign unused_addr = ^bus.address[1:0];

    assign hit_word  = data_array[index][{word_sel, 5'b0} +: WORD_W];
    assign hit       = valid[index] & (tag_array[index] == cpu_tag);
    assign access    = bus.read | bus.write;
    assign idle      = (state == IDLE);
    assign read_hit  = idle & hit & bus.read;
    assign write_hit = idle & hit & bus.write;

    // The CPU view is combinational so hits cost no cycle; reset forces both quiet.
    assign bus.busywait = ~reset & access & ~(idle & hit);
    assign bus.readdata = reset ? WORD_W'(0) : (read_hit ? hit_word : readdata_q);

    assign bus.mem_read      = mem_read_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.mem_address   = mem_address_q;
    assign bus.mem_writedata = mem_writedata_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Memory requests are derived from the next state so they line up with the state they belong to.
    always_comb begin
        next_state      = state;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        readdata_d      = readdata_q;

        case (state)
            IDLE: begin
                if (access && !hit) begin
                    next_state = (valid[index] && dirty[index]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (!bus.mem_busywait) next_state = ALLOCATE;
            end
            ALLOCATE: begin
                if (!bus.mem_busywait) next_state = UPDATE;
            end
            UPDATE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        mem_write_d = (next_state == WRITEBACK);
        mem_read_d  = (next_state == ALLOCATE);

        if (idle && next_state == WRITEBACK) begin
            mem_address_d   = {tag_array[index], index};
            mem_writedata_d = data_array[index];
        end
        if (state != ALLOCATE && next_state == ALLOCATE) begin
            mem_address_d = bus.address[31:4];
        end
        if (read_hit) begin
            readdata_d = hit_word;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            readdata_q      <= '0;
        end else begin
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            readdata_q      <= readdata_d;
        end
    end

    // Line contents survive reset; only the valid/dirty bits are cleared.
    always_ff @(posedge clock) begin
        if (state == UPDATE) begin
            data_array[index] <= bus.mem_readdata;
            tag_array[index]  <= cpu_tag;
        end else if (write_hit) begin
            data_array[index][{word_sel, 5'b0} +: WORD_W] <= bus.writedata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= '0;
            dirty <= '0;
        end else if (state == UPDATE) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (write_hit) begin
            dirty[index] <= 1'b1;
        end
    end
endmodule
